// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 unsigned MULTU/DIVU unit with HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] MULTU_AC = 4'd7;
  localparam logic [3:0] DIVU_AC  = 4'd8;
  localparam int         CW       = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [WIDTH-1:0]   opnd_q;
  // Dividend kept so a divide by zero can return it as the remainder.
  logic [WIDTH-1:0]   dvd_q;
  // MULTU: {partial product, remaining multiplier bits}; DIVU: {rem, quot}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic               busy_q, done_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               accept;
  logic               last_iter;

  assign accept    = start && (alu_ctrl == MULTU_AC || alu_ctrl == DIVU_AC) && (state_q != S_RUN);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // One shift-add or restoring-divide iteration on the accumulator.
  always_comb begin
    acc_d     = acc_q;
    mul_sum   = '0;
    div_trial = '0;
    if (is_div_q) begin
      // The bit shifted out of rem is kept as bit WIDTH of the trial operand.
      div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
      if (!div_trial[WIDTH]) begin
        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Final HI/LO values, with the divide-by-zero result made explicit.
  always_comb begin
    hi_d = acc_d[2*WIDTH-1:WIDTH];
    lo_d = acc_d[WIDTH-1:0];
    if (is_div_q && (opnd_q == '0)) begin
      hi_d = dvd_q;
      lo_d = '1;
    end
  end

  // Control FSM, operand latch, iteration counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= (alu_ctrl == DIVU_AC);
            opnd_q   <= (alu_ctrl == DIVU_AC) ? b : a;
            dvd_q    <= a;
            acc_q    <= {{WIDTH{1'b0}}, ((alu_ctrl == DIVU_AC) ? a : b)};
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed vector bench for mul_div_unit
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issue one op (accept edge = cycle 0) and observe cycles 1..40.
  task automatic run_op(input vec_t v);
    int           busy_cnt;
    int           done_cyc;
    logic [W-1:0] h, l;
    busy_cnt = 0;
    done_cyc = -1;
    h = '0;
    l = '0;
    @(negedge clk);
    start = 1'b1; alu_ctrl = v.ctrl; a = v.a; b = v.b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; alu_ctrl = 4'd0; end
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) begin done_cyc = n; h = hi; l = lo; end
    end
    check({v.name, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({v.name, "_done_cycle"}, 64'(done_cyc), 64'd33);
    check({v.name, "_hi"}, 64'(h), 64'(v.hi));
    check({v.name, "_lo"}, 64'(l), 64'(v.lo));
  endtask

  initial begin
    int           busy_cnt;
    int           done_cyc;
    int           done_cnt;
    int           done2_cyc;
    logic [W-1:0] h, l, h2, l2;

    vecs[0] = '{"mul_7x6",       4'd7, 32'd7,          32'd6,          32'h00000000, 32'h0000002A};
    vecs[1] = '{"mul_max",       4'd7, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"mul_hi_bit",    4'd7, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000};
    vecs[3] = '{"mul_16x16",     4'd7, 32'h00010000,   32'h00010000,   32'h00000001, 32'h00000000};
    vecs[4] = '{"div_100_7",     4'd8, 32'd100,        32'd7,          32'd2,        32'd14};
    vecs[5] = '{"div_5_9",       4'd8, 32'd5,          32'd9,          32'd5,        32'd0};
    vecs[6] = '{"div_by_zero",   4'd8, 32'h12345678,   32'd0,          32'h12345678, 32'hFFFFFFFF};
    vecs[7] = '{"div_max_16",    4'd8, 32'hFFFFFFFF,   32'h10,         32'h0000000F, 32'h0FFFFFFF};
    vecs[8] = '{"div_top_3",     4'd8, 32'h80000000,   32'd3,          32'd2,        32'h2AAAAAAA};

    rst = 1'b1; start = 1'b0; alu_ctrl = 4'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Ignored requests during RUN; HI/LO stay stale until completion.
    busy_cnt = 0; done_cyc = -1; h = '0; l = '0;
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd7; a = 32'd3; b = 32'd4;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; alu_ctrl = 4'd0; end
      if (n == 5) begin start = 1'b1; alu_ctrl = 4'd8; a = 32'd9; b = 32'd2; end
      if (n == 6) begin start = 1'b0; alu_ctrl = 4'd0; end
      if (n == 8) begin start = 1'b1; alu_ctrl = 4'd2; end
      if (n == 9) begin start = 1'b0; alu_ctrl = 4'd0; end
      if (n == 10) begin
        check("stale_hi_in_run", 64'(hi), 64'(vecs[8].hi));
        check("stale_lo_in_run", 64'(lo), 64'(vecs[8].lo));
      end
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) begin done_cyc = n; h = hi; l = lo; end
    end
    check("ignore_busy_cycles", 64'(busy_cnt), 64'd32);
    check("ignore_done_cycle", 64'(done_cyc), 64'd33);
    check("ignore_hi", 64'(h), 64'd0);
    check("ignore_lo", 64'(l), 64'd12);

    // Non-MULTU/DIVU code with start while idle is not accepted.
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd2; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0; alu_ctrl = 4'd0;
    check("add_no_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("add_no_done", 64'(done), 64'd0);
    check("add_lo_kept", 64'(lo), 64'd12);

    // Back-to-back: new accept in the DONE cycle.
    done_cnt = 0; done2_cyc = -1; h2 = '0; l2 = '0;
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd7; a = 32'd3; b = 32'd4;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; alu_ctrl = 4'd0; end
      if (done) done_cnt++;
      if (n == 33) begin
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_first_lo", 64'(lo), 64'd12);
        start = 1'b1; alu_ctrl = 4'd7; a = 32'd5; b = 32'd5;
      end
      if (n == 34) begin
        start = 1'b0; alu_ctrl = 4'd0;
        check("b2b_busy_after_done", 64'(busy), 64'd1);
        check("b2b_done_one_cycle", 64'(done), 64'd0);
      end
      if (n > 34 && done && done2_cyc < 0) begin done2_cyc = n; h2 = hi; l2 = lo; end
    end
    check("b2b_done_pulses", 64'(done_cnt), 64'd2);
    check("b2b_second_done_cycle", 64'(done2_cyc), 64'd66);
    check("b2b_second_hi", 64'(h2), 64'd0);
    check("b2b_second_lo", 64'(l2), 64'd25);

    // Reset at cycle 10 of a divide abandons it.
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd8; a = 32'd1000; b = 32'd3;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; alu_ctrl = 4'd0; end
      if (n == 10) rst = 1'b1;
      if (n == 11) begin
        rst = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
      end
      if (n >= 11 && done) done_cnt++;
    end
    check("rst_mid_no_done_pulse", 64'(done_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
